// File: rtl/wb_axis_bridge_if.sv
// Bus bundle for wb_axis_bridge: Wishbone classic slave port plus the AXIS request/response byte streams.
interface wb_axis_bridge_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
        output m_axis_tdata, m_axis_tvalid,
        input  m_axis_tready,
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
        input  m_axis_tdata, m_axis_tvalid,
        output m_axis_tready,
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready
    );
endinterface

// File: rtl/wb_axis_bridge.sv
// Wishbone classic slave that serialises each access into an AXIS command frame and completes it from the echoed response.
// Optional response timeout: define WB_AXIS_BRIDGE_TIMEOUT_EN.
module wb_axis_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  CMD_READ       = 8'hA1,
    parameter logic [7:0]  CMD_WRITE      = 8'hA2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    wb_axis_bridge_if.slave bus,
    output logic            o_busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX_HDR  = 3'd1,
        S_TX_DATA = 3'd2,
        S_RX_HDR  = 3'd3,
        S_RX_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic        we_q;
    logic        mismatch_q;
    logic [31:0] rdata_q;
    logic [31:0] wb_dat_q;
    logic        ack_q;
    logic        err_q;
    logic        tvalid_q;
    logic [7:0]  tdata_q;
    logic        s_tready_q;
    logic        busy_q;

    logic        req_s;
    logic        accept_s;
    logic        tx_beat_s;
    logic        rx_beat_s;
    logic [2:0]  idx_d;
    logic [7:0]  cmd_s;

    // Header byte n of the frame; the response echoes the same seven bytes.
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [7:0] cmd,
                                            input logic [31:0] adr);
        logic [7:0] b;
        case (idx)
            3'd0:    b = cmd;
            3'd1:    b = adr[31:24];
            3'd2:    b = adr[23:16];
            3'd3:    b = adr[15:8];
            3'd4:    b = adr[7:0];
            3'd5:    b = 8'h00;
            3'd6:    b = 8'h04;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign req_s     = bus.wb_cyc_i & bus.wb_stb_i;
    assign accept_s  = req_s & ~ack_q & ~err_q;
    assign tx_beat_s = tvalid_q & bus.m_axis_tready;
    assign rx_beat_s = s_tready_q & bus.s_axis_tvalid;
    assign idx_d     = idx_q + 3'd1;
    assign cmd_s     = we_q ? CMD_WRITE : CMD_READ;

`ifdef WB_AXIS_BRIDGE_TIMEOUT_EN
    logic [31:0] to_q;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = TIMEOUT_CYCLES;
`endif

    // Frame sequencer with all bus/stream outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            we_q       <= 1'b0;
            mismatch_q <= 1'b0;
            rdata_q    <= 32'd0;
            wb_dat_q   <= 32'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= 8'd0;
            s_tready_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef WB_AXIS_BRIDGE_TIMEOUT_EN
            to_q       <= 32'd0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        adr_q      <= bus.wb_adr_i;
                        dat_q      <= bus.wb_dat_i;
                        we_q       <= bus.wb_we_i;
                        mismatch_q <= 1'b0;
                        idx_q      <= 3'd0;
                        // Partial-word writes are refused locally without touching the link.
                        if (bus.wb_we_i && (bus.wb_sel_i != 4'hF)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q  <= S_TX_HDR;
                            busy_q   <= 1'b1;
                            tvalid_q <= 1'b1;
                            tdata_q  <= bus.wb_we_i ? CMD_WRITE : CMD_READ;
                        end
                    end
                end
                S_TX_HDR: begin
                    if (tx_beat_s) begin
                        if (idx_q == 3'd6) begin
                            idx_q <= 3'd0;
                            if (we_q) begin
                                state_q <= S_TX_DATA;
                                tdata_q <= dat_q[7:0];
                                dat_q   <= {8'h00, dat_q[31:8]};
                            end else begin
                                state_q    <= S_RX_HDR;
                                tvalid_q   <= 1'b0;
                                s_tready_q <= 1'b1;
                            end
                        end else begin
                            idx_q   <= idx_d;
                            tdata_q <= hdr_byte(idx_d, cmd_s, adr_q);
                        end
                    end
                end
                S_TX_DATA: begin
                    if (tx_beat_s) begin
                        if (idx_q == 3'd3) begin
                            idx_q      <= 3'd0;
                            state_q    <= S_RX_HDR;
                            tvalid_q   <= 1'b0;
                            s_tready_q <= 1'b1;
                        end else begin
                            idx_q   <= idx_d;
                            tdata_q <= dat_q[7:0];
                            dat_q   <= {8'h00, dat_q[31:8]};
                        end
                    end
                end
                S_RX_HDR: begin
                    if (rx_beat_s) begin
                        if (bus.s_axis_tdata != hdr_byte(idx_q, cmd_s, adr_q)) begin
                            mismatch_q <= 1'b1;
                        end
                        if (idx_q == 3'd6) begin
                            idx_q <= 3'd0;
                            if (we_q) begin
                                state_q    <= S_DONE;
                                s_tready_q <= 1'b0;
                            end else begin
                                state_q <= S_RX_DATA;
                            end
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (rx_beat_s) begin
                        rdata_q <= {bus.s_axis_tdata, rdata_q[31:8]};
                        if (idx_q == 3'd3) begin
                            idx_q      <= 3'd0;
                            state_q    <= S_DONE;
                            s_tready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    // An abandoned cycle gets no completion, but the link stays framed.
                    if (req_s) begin
                        if (mismatch_q) begin
                            err_q <= 1'b1;
                        end else begin
                            ack_q <= 1'b1;
                            if (!we_q) begin
                                wb_dat_q <= rdata_q;
                            end
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    tvalid_q   <= 1'b0;
                    s_tready_q <= 1'b0;
                end
            endcase
`ifdef WB_AXIS_BRIDGE_TIMEOUT_EN
            // Silence watchdog: any response beat restarts it; expiry forces an error completion.
            if ((state_q == S_RX_HDR) || (state_q == S_RX_DATA)) begin
                if (rx_beat_s) begin
                    to_q <= 32'd0;
                end else if (to_q == (TIMEOUT_CYCLES - 32'd1)) begin
                    to_q       <= 32'd0;
                    state_q    <= S_DONE;
                    mismatch_q <= 1'b1;
                    s_tready_q <= 1'b0;
                end else begin
                    to_q <= to_q + 32'd1;
                end
            end else begin
                to_q <= 32'd0;
            end
`endif
        end
    end

    assign bus.wb_dat_o      = wb_dat_q;
    assign bus.wb_ack_o      = ack_q;
    assign bus.wb_err_o      = err_q;
    assign bus.wb_rty_o      = 1'b0;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.s_axis_tready = s_tready_q;
    assign o_busy            = busy_q;

endmodule
